fifo_read_unpacker: RTL
=======================

// Module: fifo_read_unpacker
// PURPOSE
//  Drain stage on the pop side of the pow2-depth flip-flop FIFO. Takes wide FIFO
//  words, splits each into RATIO = IN_WIDTH/OUT_WIDTH narrow beats and presents
//  them on a valid/ready stream. Holds one word in an internal register, so the
//  FIFO's combinational read_data never reaches the downstream consumer directly.
//  Sustains one beat per cycle with no bubble between consecutive words.
// PARAMETERS
//  IN_WIDTH   64  FIFO word width; must equal the FIFO width parameter
//  OUT_WIDTH  16  beat width; IN_WIDTH % OUT_WIDTH == 0; RATIO power of two, >= 2
//  MSB_FIRST  0   0: beat 0 = bits [OUT_WIDTH-1:0]; 1: beat 0 = top OUT_WIDTH bits
// PORTS
//  clk             in   1          clock, rising edge
//  rst             in   1          reset, asynchronous, active-high
//  fifo_read_data  in   IN_WIDTH   FIFO head word (combinational FIFO read)
//  fifo_empty      in   1          FIFO empty flag
//  fifo_pop        out  1          pop request to FIFO; combinational
//  out_valid       out  1          beat available
//  out_ready       in   1          consumer accepts beat
//  out_data        out  OUT_WIDTH  current beat
//  out_last        out  1          current beat is the last beat of its word
//  busy            out  1          = out_valid (a word is partially or fully held)
// BEHAVIOUR
//  State: hold_q [IN_WIDTH], hold_valid_q, beat_q [$clog2(RATIO)].
//  Reset (async): hold_valid_q=0, beat_q=0, hold_q not reset. Outputs during reset:
//   out_valid=0, out_last=0, fifo_pop=0, busy=0; out_data don't-care.
//  accept    = out_valid & out_ready.
//  last_beat = (beat_q == RATIO-1).
//  fifo_pop  = !fifo_empty & (!hold_valid_q | (accept & last_beat)).
//   - Never asserted while fifo_empty=1.
//   - Depends on out_ready combinationally; out_ready must not depend on fifo_pop.
//  On fifo_pop: hold_q <= fifo_read_data, hold_valid_q <= 1, beat_q <= 0.
//  Else on accept & last_beat: hold_valid_q <= 0, beat_q <= 0.
//  Else on accept: beat_q <= beat_q + 1.
//  out_valid = hold_valid_q. out_last = hold_valid_q & last_beat.
//  out_data = hold_q slice index beat_q (MSB_FIRST=0) or RATIO-1-beat_q (MSB_FIRST=1).
//  Latency: word at FIFO head with fifo_empty=0 in cycle N, hold empty -> pop in
//   cycle N, first beat valid in cycle N+1.
//  Throughput: last beat accepted in cycle M with FIFO non-empty -> next word's
//   beat 0 valid in cycle M+1 (no bubble).
//  Backpressure: while out_valid=1 and out_ready=0, out_data, out_last and
//   beat_q hold stable, and fifo_pop=0.
//  Valid rule: out_valid, once asserted, never drops before acceptance.
//  beat_q wraps RATIO-1 -> 0 only by load or last-beat accept, never by overflow.
//  Reset mid-word: the partial word is discarded, and already-popped data is not
//   re-read. The FIFO shares rst, so both sides restart empty.
//  X-safety: fifo_read_data is sampled only when fifo_pop=1.
// TESTING
//  T1 RATIO=4, push 64'h0004_0003_0002_0001, out_ready=1 -> out_data 1,2,3,4 on
//   4 consecutive cycles; out_last=1 only on 4; one fifo_pop pulse.
//  T2 Two words queued, out_ready=1 -> 8 beats in 8 consecutive cycles; fifo_pop
//   high in cycle 0 and cycle 4 only; out_last on beats 4 and 8.
//  T3 out_ready=0 for 5 cycles at beat 2 -> out_data=16'h0002 stable; fifo_pop=0;
//   after release, beats continue 2,3,4.
//  T4 FIFO empty, out_ready=1 for 20 cycles -> fifo_pop=0, out_valid=0 throughout.
//  T5 rst pulse after beat 1 accepted -> out_valid=0 the next cycle. A new word
//   pushed afterwards emits from its beat 0.
//  T6 MSB_FIRST=1, same word as T1 -> beats 4,3,2,1; out_last on 1.
//  Random stall/push stress vs. reference model, FIFO depth 4: beat order exact,
//   no pop when empty, FIFO never overflows.

Source files
------------

// File: rtl/fifo_read_unpacker.sv
// Pop-side drain stage: splits each wide FIFO word into RATIO narrow beats on a valid/ready stream.
// The head word is captured into hold_q, so downstream never sees the FIFO's combinational read port.
module fifo_read_unpacker #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 16,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  fifo_read_data,
  input  logic                 fifo_empty,
  output logic                 fifo_pop,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 busy
);
  localparam int RATIO  = IN_WIDTH / OUT_WIDTH;
  localparam int BEAT_W = $clog2(RATIO);
  localparam logic [BEAT_W-1:0] LAST_IDX = BEAT_W'(RATIO - 1);

  if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
    $error("fifo_read_unpacker: IN_WIDTH/OUT_WIDTH must be an integer power of two >= 2");
  end

  logic [IN_WIDTH-1:0]  hold_q;
  logic                 hold_valid_q, hold_valid_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic                 accept;
  logic                 last_beat;
  logic [BEAT_W-1:0]    slice_sel;
  logic [OUT_WIDTH-1:0] beats [RATIO];

  assign accept    = hold_valid_q & out_ready;
  assign last_beat = (beat_q == LAST_IDX);
  // Gated by rst so nothing is popped (and lost) while the hold register is forced empty.
  assign fifo_pop  = !rst & !fifo_empty & (!hold_valid_q | (accept & last_beat));

  always_comb begin
    hold_valid_d = hold_valid_q;
    beat_d       = beat_q;
    if (fifo_pop) begin
      hold_valid_d = 1'b1;
      beat_d       = '0;
    end else if (accept & last_beat) begin
      hold_valid_d = 1'b0;
      beat_d       = '0;
    end else if (accept) begin
      beat_d = beat_q + BEAT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      beat_q       <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      beat_q       <= beat_d;
    end
  end

  // Data register carries no reset; it is only meaningful while hold_valid_q is set.
  always_ff @(posedge clk) begin
    if (fifo_pop) begin
      hold_q <= fifo_read_data;
    end
  end

  always_comb begin
    for (int i = 0; i < RATIO; i++) begin
      beats[i] = hold_q[i*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  assign slice_sel = MSB_FIRST ? (LAST_IDX - beat_q) : beat_q;
  assign out_data  = beats[slice_sel];
  assign out_valid = hold_valid_q;
  assign out_last  = hold_valid_q & last_beat;
  assign busy      = hold_valid_q;

endmodule
